// File: rtl/field_pkg.sv
// Shared definitions for the memory-extension field sequencer:
// command opcodes, sequencer states and the default field width.
package field_pkg;

    localparam int FIELD_BITS_DEF = 1;

    typedef enum logic [2:0] {
        OP_CDF = 3'd0,
        OP_CIF = 3'd1,
        OP_CDI = 3'd2,
        OP_RDF = 3'd3,
        OP_RIF = 3'd4,
        OP_RIB = 3'd5,
        OP_RMF = 3'd6,
        OP_RSV = 3'd7
    } op_e;

    typedef enum logic {
        IDLE    = 1'b0,
        IB_PEND = 1'b1
    } state_e;

    // Ops that put a new value into IB and so leave an IF change pending.
    function automatic logic loads_ib(op_e op);
        return (op == OP_CIF) || (op == OP_CDI) || (op == OP_RMF);
    endfunction

    function automatic logic is_read(op_e op);
        return (op == OP_RDF) || (op == OP_RIF) || (op == OP_RIB) || (op == OP_RMF);
    endfunction

endpackage

// File: rtl/field_reg.sv
// W-bit field register with asynchronous active-low clear and load enable.
module field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)   q <= '0;
        else if (ld) q <= d;
    end

endmodule

// File: rtl/field_ctrl.sv
// Field register sequencer: decodes field IOTs, defers IF changes to the next
// JMP/JMS, saves/clears fields on interrupt entry and drives the high address bits.
module field_ctrl
    import field_pkg::*;
#(
    parameter int FIELD_BITS = FIELD_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [FIELD_BITS-1:0]   cmd_field,
    input  logic                    jmp_strobe,
    input  logic                    int_ack,
    input  logic                    deref,
    input  logic                    state_exec,
    output logic                    rd_valid,
    output logic [2*FIELD_BITS-1:0] rd_data,
    output logic                    int_inhibit,
    output logic [FIELD_BITS-1:0]   abus_field
);

    localparam int FB = FIELD_BITS;

    state_e state;
    op_e    op;
    logic   acc;

    logic          df_ld, if_ld, ib_ld, sf_ld;
    logic [FB-1:0] df_d, if_d, ib_d, df_q, if_q, ib_q;
    logic [2*FB-1:0] sf_d, sf_q;

    assign op          = op_e'(cmd_op);
    assign cmd_ready   = ~int_ack;
    assign acc         = cmd_valid & cmd_ready;
    assign int_inhibit = (state == IB_PEND);
    assign abus_field  = (deref | state_exec) ? df_q : if_q;

    field_reg #(.W(FB))   u_df (.clk(clk), .nrst(nrst), .ld(df_ld), .d(df_d), .q(df_q));
    field_reg #(.W(FB))   u_if (.clk(clk), .nrst(nrst), .ld(if_ld), .d(if_d), .q(if_q));
    field_reg #(.W(FB))   u_ib (.clk(clk), .nrst(nrst), .ld(ib_ld), .d(ib_d), .q(ib_q));
    field_reg #(.W(2*FB)) u_sf (.clk(clk), .nrst(nrst), .ld(sf_ld), .d(sf_d), .q(sf_q));

    always_comb begin
        df_ld = 1'b0; df_d = df_q;
        if_ld = 1'b0; if_d = if_q;
        ib_ld = 1'b0; ib_d = ib_q;
        sf_ld = 1'b0; sf_d = sf_q;
        if (int_ack) begin
            // Interrupt entry beats any jump this cycle: the pending IB is dropped.
            sf_ld = 1'b1; sf_d = {if_q, df_q};
            df_ld = 1'b1; df_d = '0;
            if_ld = 1'b1; if_d = '0;
            ib_ld = 1'b1; ib_d = '0;
        end else begin
            if (jmp_strobe && state == IB_PEND) begin
                if_ld = 1'b1; if_d = ib_q;
            end
            if (acc) begin
                case (op)
                    OP_CDF: begin df_ld = 1'b1; df_d = cmd_field; end
                    OP_CIF: begin ib_ld = 1'b1; ib_d = cmd_field; end
                    OP_CDI: begin
                        df_ld = 1'b1; df_d = cmd_field;
                        ib_ld = 1'b1; ib_d = cmd_field;
                    end
                    OP_RMF: begin
                        ib_ld = 1'b1; ib_d = sf_q[2*FB-1:FB];
                        df_ld = 1'b1; df_d = sf_q[FB-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (int_ack)                   state <= IDLE;
            else if (acc && loads_ib(op))  state <= IB_PEND;
            else if (jmp_strobe)           state <= IDLE;

            rd_valid <= acc && is_read(op);
            if (acc) begin
                case (op)
                    OP_RDF:  rd_data <= {{FB{1'b0}}, df_q};
                    OP_RIF:  rd_data <= {{FB{1'b0}}, if_q};
                    OP_RIB:  rd_data <= {{FB{1'b0}}, ib_q};
                    OP_RMF:  rd_data <= sf_q;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_field_ctrl.sv
// Scoreboarded bench for field_ctrl: reads push expected data, the monitor pops on rd_valid.
module tb_field_ctrl;
    import field_pkg::*;

    localparam int FB = 1;

    logic          clk = 1'b0;
    logic          nrst;
    logic          cmd_valid, cmd_ready, jmp_strobe, int_ack, deref, state_exec;
    logic [2:0]    cmd_op;
    logic [FB-1:0] cmd_field;
    logic          rd_valid, int_inhibit;
    logic [2*FB-1:0] rd_data;
    logic [FB-1:0]   abus_field;

    int n_vec = 0;
    int n_err = 0;
    logic [2*FB-1:0] sb[$];

    field_ctrl #(.FIELD_BITS(FB)) dut (
        .clk(clk), .nrst(nrst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_field(cmd_field), .jmp_strobe(jmp_strobe),
        .int_ack(int_ack), .deref(deref), .state_exec(state_exec),
        .rd_valid(rd_valid), .rd_data(rd_data), .int_inhibit(int_inhibit),
        .abus_field(abus_field)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb.size() == 0) chk("rd_valid_unexp", 32'(rd_valid), 32'd0);
            else                chk("rd_data", 32'(rd_data), 32'(sb.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        jmp_strobe = 1'b0;
        int_ack    = 1'b0;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [FB-1:0] f);
        cmd_valid = 1'b1; cmd_op = op; cmd_field = f;
        step();
    endtask

    task automatic rd(input logic [2:0] op, input logic [2*FB-1:0] exp);
        sb.push_back(exp);
        cmd(op, '0);
    endtask

    task automatic abus_chk(input string tag, input logic dr, input logic se, input logic [FB-1:0] exp);
        deref = dr; state_exec = se;
        #1;
        chk(tag, 32'(abus_field), 32'(exp));
        deref = 1'b0; state_exec = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, scoreboard depth %0d", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        nrst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_field = '0;
        jmp_strobe = 1'b0; int_ack = 1'b0; deref = 1'b0; state_exec = 1'b0;
        #12;
        chk("rst_ready",   32'(cmd_ready),   32'd1);
        chk("rst_inhibit", 32'(int_inhibit), 32'd0);
        chk("rst_abus",    32'(abus_field),  32'd0);
        chk("rst_rdvalid", 32'(rd_valid),    32'd0);
        step();
        nrst = 1'b1;
        step();

        // DF select via deref / state_exec
        cmd(OP_CDF, 1'b1);
        abus_chk("cdf_deref", 1'b1, 1'b0, 1'b1);
        abus_chk("cdf_fetch", 1'b0, 1'b0, 1'b0);
        abus_chk("cdf_exec",  1'b0, 1'b1, 1'b1);
        rd(OP_RDF, 2'b01);

        // IF change deferred until the jump
        cmd(OP_CIF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("pend_abus",    32'(abus_field),  32'd0);
            chk("pend_inhibit", 32'(int_inhibit), 32'd1);
            step();
        end
        jmp_strobe = 1'b1;
        step();
        chk("jmp_inhibit", 32'(int_inhibit), 32'd0);
        chk("jmp_abus",    32'(abus_field),  32'd1);
        rd(OP_RIF, 2'b01);

        // interrupt save, then restore with RMF
        cmd(OP_CDF, 1'b0);
        int_ack = 1'b1;
        step();
        chk("int_inhibit", 32'(int_inhibit), 32'd0);
        abus_chk("int_if", 1'b0, 1'b0, 1'b0);
        abus_chk("int_df", 1'b0, 1'b1, 1'b0);
        rd(OP_RIF, 2'b00);
        rd(OP_RMF, 2'b10);
        chk("rmf_inhibit", 32'(int_inhibit), 32'd1);
        rd(OP_RIB, 2'b01);
        rd(OP_RDF, 2'b00);
        jmp_strobe = 1'b1;
        step();
        rd(OP_RIF, 2'b01);
        chk("rmf_jmp_inhibit", 32'(int_inhibit), 32'd0);

        // command blocked by int_ack, held and accepted next cycle
        cmd_valid = 1'b1; cmd_op = OP_CDF; cmd_field = 1'b1; int_ack = 1'b1;
        #1;
        chk("ack_ready", 32'(cmd_ready), 32'd0);
        step();
        abus_chk("ack_df_blocked", 1'b1, 1'b0, 1'b0);
        cmd_valid = 1'b1; cmd_op = OP_CDF; cmd_field = 1'b1;
        #1;
        chk("held_ready", 32'(cmd_ready), 32'd1);
        step();
        abus_chk("held_df", 1'b1, 1'b0, 1'b1);

        // jump and CIF in the same cycle
        cmd(OP_CIF, 1'b1);
        jmp_strobe = 1'b1;
        cmd(OP_CIF, 1'b0);
        chk("jmpcif_inhibit", 32'(int_inhibit), 32'd1);
        rd(OP_RIF, 2'b01);
        rd(OP_RIB, 2'b00);
        jmp_strobe = 1'b1;
        step();
        chk("jmpcif_done", 32'(int_inhibit), 32'd0);

        // jump and int_ack together: SF holds the pre-jump IF
        cmd(OP_CIF, 1'b1);
        jmp_strobe = 1'b1; int_ack = 1'b1;
        step();
        chk("jmpack_inhibit", 32'(int_inhibit), 32'd0);
        rd(OP_RMF, 2'b01);
        rd(OP_RIB, 2'b00);
        rd(OP_RDF, 2'b01);
        chk("jmpack_rmf_inh", 32'(int_inhibit), 32'd1);
        jmp_strobe = 1'b1;
        step();

        // reserved op: no read, no state change
        cmd(OP_RSV, 1'b1);
        rd(OP_RDF, 2'b01);
        chk("rsv_inhibit", 32'(int_inhibit), 32'd0);

        // reset while an IF change is pending
        cmd(OP_CIF, 1'b1);
        chk("pre_rst_inh", 32'(int_inhibit), 32'd1);
        step();
        nrst = 1'b0;
        #1;
        chk("mid_rst_inh", 32'(int_inhibit), 32'd0);
        abus_chk("mid_rst_df", 1'b1, 1'b0, 1'b0);
        abus_chk("mid_rst_if", 1'b0, 1'b0, 1'b0);
        step();
        nrst = 1'b1;
        jmp_strobe = 1'b1;
        step();
        rd(OP_RIF, 2'b00);
        rd(OP_RIB, 2'b00);
        rd(OP_RDF, 2'b00);

        step();
        step();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
